// File: rtl/btn_conditioner.sv
// Five-button input stage: two-flop synchronizer, per-button debounce, press/release
// strobes, hold-then-repeat strobes and a priority-encoded one-hot command.
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int HOLD_CYC     = 12500000,
    parameter int REPEAT_CYC   = 2500000,
    parameter int CNT_W        = 24
) (
    input  logic       CLK_OUT3,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] press_pulse,
    output logic [4:0] release_pulse,
    output logic [4:0] rep_pulse,
    output logic [4:0] cmd,
    output logic       cmd_valid,
    output logic       any_held
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_t;

    logic [4:0] r_s1;
    logic [4:0] r_s2;
    logic [4:0] w_rise;
    logic [4:0] w_fall;
    logic [4:0] w_stable_next;
    logic [4:0] w_rep;
    logic [4:0] w_cmd;

    always_ff @(posedge CLK_OUT3) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic             r_stable;
            logic [CNT_W-1:0] r_dcnt;
            logic             w_done;
            logic             w_rise_b;
            logic             w_fall_b;
            state_t           r_state;
            state_t           w_state_next;
            logic [CNT_W-1:0] r_rcnt;
            logic [CNT_W-1:0] w_rcnt_next;
            logic             w_rep_b;

            // The count restarts whenever the synchronized input agrees with the
            // stable level again, so only an unbroken run can flip it.
            assign w_done   = (r_s2[gi] != r_stable) && (r_dcnt == DEB_LAST);
            assign w_rise_b = w_done & r_s2[gi];
            assign w_fall_b = w_done & ~r_s2[gi];

            always_ff @(posedge CLK_OUT3) begin
                if (rst) begin
                    r_stable <= 1'b0;
                    r_dcnt   <= '0;
                end else if (r_s2[gi] == r_stable) begin
                    r_dcnt <= '0;
                end else if (w_done) begin
                    r_stable <= r_s2[gi];
                    r_dcnt   <= '0;
                end else begin
                    r_dcnt <= r_dcnt + CNT_ONE;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_rcnt_next  = r_rcnt;
                w_rep_b      = 1'b0;
                case (r_state)
                    IDLE: begin
                        if (w_rise_b) begin
                            w_rep_b      = 1'b1;
                            w_rcnt_next  = '0;
                            w_state_next = HOLD;
                        end
                    end
                    HOLD: begin
                        if (w_fall_b) begin
                            w_rcnt_next  = '0;
                            w_state_next = IDLE;
                        end else if (r_rcnt == HOLD_LAST) begin
                            w_rep_b      = 1'b1;
                            w_rcnt_next  = '0;
                            w_state_next = RPT;
                        end else begin
                            w_rcnt_next = r_rcnt + CNT_ONE;
                        end
                    end
                    RPT: begin
                        // A release wins over a repeat falling due in the same cycle.
                        if (w_fall_b) begin
                            w_rcnt_next  = '0;
                            w_state_next = IDLE;
                        end else if (r_rcnt == RPT_LAST) begin
                            w_rep_b     = 1'b1;
                            w_rcnt_next = '0;
                        end else begin
                            w_rcnt_next = r_rcnt + CNT_ONE;
                        end
                    end
                    default: begin
                        w_rcnt_next  = '0;
                        w_state_next = IDLE;
                    end
                endcase
            end

            always_ff @(posedge CLK_OUT3) begin
                if (rst) begin
                    r_state <= IDLE;
                    r_rcnt  <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_rcnt  <= w_rcnt_next;
                end
            end

            assign w_rise[gi]        = w_rise_b;
            assign w_fall[gi]        = w_fall_b;
            assign w_stable_next[gi] = w_done ? r_s2[gi] : r_stable;
            assign w_rep[gi]         = w_rep_b;
        end
    endgenerate

    // Isolating the lowest set bit gives bit0 (btnc) the highest priority.
    assign w_cmd = w_rep & (~w_rep + 5'd1);

    always_ff @(posedge CLK_OUT3) begin
        if (rst) begin
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            rep_pulse     <= '0;
            cmd           <= '0;
            cmd_valid     <= 1'b0;
            any_held      <= 1'b0;
        end else begin
            btn_level     <= w_stable_next;
            press_pulse   <= w_rise;
            release_pulse <= w_fall;
            rep_pulse     <= w_rep;
            cmd           <= w_cmd;
            cmd_valid     <= |w_rep;
            any_held      <= |w_stable_next;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/hold/repeat periods.
module tb_btn_conditioner;

    logic       CLK_OUT3;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] press_pulse;
    logic [4:0] release_pulse;
    logic [4:0] rep_pulse;
    logic [4:0] cmd;
    logic       cmd_valid;
    logic       any_held;

    int total;
    int bad;

    btn_conditioner #(
        .DEBOUNCE_CYC(4),
        .HOLD_CYC    (10),
        .REPEAT_CYC  (3),
        .CNT_W       (8)
    ) dut (
        .CLK_OUT3     (CLK_OUT3),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .rep_pulse    (rep_pulse),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .any_held     (any_held)
    );

    initial CLK_OUT3 = 1'b0;
    always #5 CLK_OUT3 = ~CLK_OUT3;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_OUT3);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".level"},   {27'd0, btn_level},     32'd0);
        chk({tag, ".press"},   {27'd0, press_pulse},   32'd0);
        chk({tag, ".release"}, {27'd0, release_pulse}, 32'd0);
        chk({tag, ".rep"},     {27'd0, rep_pulse},     32'd0);
        chk({tag, ".cmd"},     {27'd0, cmd},           32'd0);
        chk({tag, ".flags"},   {30'd0, cmd_valid, any_held}, 32'd0);
    endtask

    initial begin
        int pcount;
        int rcount;
        int pcyc;
        int rcyc;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        btn_raw = 5'b00000;
        tick(3);
        chk_all_zero("reset");

        // Test 1: bit0 held from cycle 0, levels/pulses rise at edge 6.
        rst     = 1'b0;
        btn_raw = 5'b00001;
        tick(5);
        chk("t1.level_e5", {27'd0, btn_level}, 32'd0);
        chk("t1.press_e5", {27'd0, press_pulse}, 32'd0);
        tick(1);
        chk("t1.level_e6", {27'd0, btn_level}, 32'h01);
        chk("t1.press_e6", {27'd0, press_pulse}, 32'h01);
        chk("t1.rep_e6", {27'd0, rep_pulse}, 32'h01);
        chk("t1.cmd_e6", {27'd0, cmd}, 32'h01);
        chk("t1.valid_e6", {31'd0, cmd_valid}, 32'd1);
        chk("t1.held_e6", {31'd0, any_held}, 32'd1);
        tick(1);
        chk("t1.press_e7", {27'd0, press_pulse}, 32'd0);
        chk("t1.rep_e7", {27'd0, rep_pulse}, 32'd0);
        chk("t1.cmd_e7", {27'd0, cmd}, 32'd0);
        chk("t1.valid_e7", {31'd0, cmd_valid}, 32'd0);
        chk("t1.level_e7", {27'd0, btn_level}, 32'h01);
        btn_raw = 5'b00000;
        tick(6);
        chk("t1.release", {27'd0, release_pulse}, 32'h01);
        chk("t1.level_rel", {27'd0, btn_level}, 32'd0);
        chk("t1.held_rel", {31'd0, any_held}, 32'd0);
        tick(1);
        chk("t1.release_end", {27'd0, release_pulse}, 32'd0);
        tick(3);

        // Test 2: 3-cycle high glitch on bit2 is rejected.
        btn_raw = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t2.glitch_level", {27'd0, btn_level}, 32'd0);
        end
        btn_raw = 5'b00000;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t2.glitch_level", {27'd0, btn_level}, 32'd0);
            chk("t2.glitch_press", {27'd0, press_pulse}, 32'd0);
        end
        // Steady press, then a 1-cycle low glitch.
        btn_raw = 5'b00100;
        tick(6);
        chk("t2.press", {27'd0, press_pulse}, 32'h04);
        btn_raw = 5'b00000;
        tick(1);
        btn_raw = 5'b00100;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t2.dip_level", {27'd0, btn_level}, 32'h04);
            chk("t2.dip_release", {27'd0, release_pulse}, 32'd0);
            chk("t2.dip_rep", {27'd0, rep_pulse}, 32'd0);
        end
        btn_raw = 5'b00000;
        tick(3);
        chk("t2.rep_hold", {27'd0, rep_pulse}, 32'h04);
        tick(3);
        chk("t2.release", {27'd0, release_pulse}, 32'h04);
        chk("t2.rep_at_release", {27'd0, rep_pulse}, 32'd0);
        tick(3);

        // Test 3: bit1 hold and repeat.
        btn_raw = 5'b00010;
        tick(6);
        chk("t3.rep_P", {27'd0, rep_pulse}, 32'h02);
        chk("t3.cmd_P", {27'd0, cmd}, 32'h02);
        tick(9);
        chk("t3.rep_P9", {27'd0, rep_pulse}, 32'd0);
        tick(1);
        chk("t3.rep_P10", {27'd0, rep_pulse}, 32'h02);
        tick(2);
        chk("t3.rep_P12", {27'd0, rep_pulse}, 32'd0);
        tick(1);
        chk("t3.rep_P13", {27'd0, rep_pulse}, 32'h02);
        tick(3);
        chk("t3.rep_P16", {27'd0, rep_pulse}, 32'h02);
        btn_raw = 5'b00000;
        tick(3);
        chk("t3.rep_P19", {27'd0, rep_pulse}, 32'h02);
        tick(3);
        chk("t3.release", {27'd0, release_pulse}, 32'h02);
        chk("t3.rep_at_release", {27'd0, rep_pulse}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t3.rep_after", {27'd0, rep_pulse}, 32'd0);
        end

        // Test 4: simultaneous presses on bits 1, 2, 4.
        btn_raw = 5'b10110;
        tick(6);
        chk("t4.rep", {27'd0, rep_pulse}, 32'h16);
        chk("t4.press", {27'd0, press_pulse}, 32'h16);
        chk("t4.cmd", {27'd0, cmd}, 32'h02);
        chk("t4.valid", {31'd0, cmd_valid}, 32'd1);
        btn_raw = 5'b00000;
        tick(6);
        chk("t4.release", {27'd0, release_pulse}, 32'h16);
        chk("t4.held", {31'd0, any_held}, 32'd0);
        tick(3);

        // Test 5: reset while bit3 is in repeat, then fresh press.
        btn_raw = 5'b01000;
        tick(6);
        chk("t5.press", {27'd0, press_pulse}, 32'h08);
        tick(10);
        chk("t5.rep_hold", {27'd0, rep_pulse}, 32'h08);
        chk("t5.cmd_hold", {27'd0, cmd}, 32'h08);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk_all_zero("t5.rst1");
        tick(1);
        chk_all_zero("t5.rst2");
        rst = 1'b0;
        tick(5);
        chk("t5.level_e5", {27'd0, btn_level}, 32'd0);
        chk("t5.press_e5", {27'd0, press_pulse}, 32'd0);
        tick(1);
        chk("t5.level_e6", {27'd0, btn_level}, 32'h08);
        chk("t5.press_e6", {27'd0, press_pulse}, 32'h08);
        chk("t5.cmd_e6", {27'd0, cmd}, 32'h08);
        btn_raw = 5'b00000;
        tick(6);
        chk("t5.release", {27'd0, release_pulse}, 32'h08);
        tick(3);

        // Test 6: bit4 held 20 cycles.
        pcount  = 0;
        rcount  = 0;
        pcyc    = -1;
        rcyc    = -1;
        btn_raw = 5'b10000;
        for (int i = 1; i <= 32; i++) begin
            tick(1);
            if (press_pulse[4]) begin
                pcount++;
                pcyc = i;
            end
            if (release_pulse[4]) begin
                rcount++;
                rcyc = i;
            end
            chk("t6.any_held", {31'd0, any_held}, (i >= 6 && i <= 25) ? 32'd1 : 32'd0);
            if (i == 20) btn_raw = 5'b00000;
        end
        chk("t6.press_count", pcount, 32'd1);
        chk("t6.release_count", rcount, 32'd1);
        chk("t6.press_cycle", pcyc, 32'd6);
        chk("t6.spacing", rcyc - pcyc, 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage between the five raw push-buttons (btnc, btnl, btnr, btnu, btnd) and the colour/scroll control logic.
- Synchronizes and debounces each button, then emits registered levels, single-cycle press/release strobes and auto-repeat strobes.
- Also emits a priority-encoded one-hot command, so consumers no longer need their own "stop" latch for edge detection.

Parameters:
- DEBOUNCE_CYC, 250000: consecutive stable cycles required before the debounced level changes; legal range 1 to 2^CNT_W-1.
- HOLD_CYC, 12500000: cycles from the press strobe to the first auto-repeat strobe; legal range 1 to 2^CNT_W-1.
- REPEAT_CYC, 2500000: cycles between subsequent auto-repeat strobes; legal range 1 to 2^CNT_W-1.
- CNT_W, 24: width of every internal counter.

Ports:
- CLK_OUT3  in  1  clock; clock-wizard output, the only clock of the block.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  5  asynchronous buttons: bit0=btnc, bit1=btnl, bit2=btnr, bit3=btnu, bit4=btnd; active-high.
- btn_level  out  5  debounced level per button.
- press_pulse  out  5  one-cycle strobe on each debounced 0->1 transition.
- release_pulse  out  5  one-cycle strobe on each debounced 1->0 transition.
- rep_pulse  out  5  press strobe OR auto-repeat strobe, per button.
- cmd  out  5  one-hot: highest-priority set bit of rep_pulse this cycle.
- cmd_valid  out  1  equals |cmd.
- any_held  out  1  equals |btn_level.

Behaviour:
- All outputs are registered and clear to 0 on rst. All counters and FSMs clear to 0 / IDLE on rst.
- Synchronizer: two flops per bit (s1, s2), reset to 0.
- Debounce, per bit:
  - stable register and counter dcnt.
  - If s2 == stable: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYC-1: stable <= s2 and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any glitch shorter than DEBOUNCE_CYC cycles is fully rejected, because the count restarts whenever s2 returns to stable.
- Latency: after btn_raw changes and then stays constant, btn_level changes exactly 2+DEBOUNCE_CYC rising edges later.
- press_pulse / release_pulse assert in the same cycle btn_level first shows the new value, for exactly 1 cycle.
- Repeat FSM per bit, with counter rcnt:
  - IDLE: on the press strobe, set rep_pulse=1, rcnt <= 0, go to HOLD.
  - HOLD: rcnt increments each cycle. When rcnt == HOLD_CYC-1, set rep_pulse=1, rcnt <= 0, go to RPT.
  - RPT: rcnt increments each cycle. When rcnt == REPEAT_CYC-1, set rep_pulse=1 and rcnt <= 0.
  - In HOLD or RPT, a debounced release returns the FSM to IDLE in that cycle with no rep_pulse, and rcnt <= 0.
- rep_pulse timing: the first rep_pulse coincides with press_pulse. The second follows HOLD_CYC cycles later. Subsequent ones are spaced REPEAT_CYC cycles apart.
- Command encoder:
  - Priority is btnc > btnl > btnr > btnu > btnd (bit0 highest).
  - cmd is computed from the same-cycle rep_pulse decisions, so cmd is coincident with rep_pulse, not one cycle later.
  - Lower-priority simultaneous strobes are dropped from cmd but still appear on rep_pulse.
- Simultaneous events:
  - Independent buttons never interact except through cmd priority.
  - Press and release of the same bit cannot occur in the same cycle.
- Reset mid-operation: all state is cleared. A button still held after rst deasserts is re-synchronized and re-debounced, and produces a fresh press_pulse 2+DEBOUNCE_CYC cycles after rst deasserts.
- No arithmetic overflow: every counter wraps only through the explicit compare-and-clear conditions above.

Test Plan:
1. DEBOUNCE_CYC=4, hold btn_raw[0] high from cycle 0 -> btn_level[0], press_pulse[0], rep_pulse[0], cmd=5'b00001 and cmd_valid all rise at cycle 6. Pulses fall at cycle 7; btn_level stays 1.
2. DEBOUNCE_CYC=4, 3-cycle high glitch on btn_raw[2], then a 1-cycle low glitch during a steady press -> no change on btn_level, no pulses.
3. HOLD_CYC=10, REPEAT_CYC=3, hold bit1 -> rep_pulse[1] at press cycle P, then at P+10, P+13, P+16. Release -> release_pulse[1] fires and no further rep_pulse[1].
4. Presses on bits 1, 2 and 4 debounce in the same cycle -> rep_pulse=5'b10110, cmd=5'b00010.
5. Assert rst for 2 cycles while bit3 is held in RPT -> all outputs 0 during reset. After deassert, btn_level[3] and press_pulse[3] assert 2+DEBOUNCE_CYC cycles later.
6. Press and release bit4 (held 20 cycles, DEBOUNCE_CYC=4) -> exactly one press_pulse and one release_pulse, spaced 20 cycles apart; any_held is high only between them.
